// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone master multiplexer.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TOUT = 2'd2
  } mmux_state_t;

  localparam int WB_NM = 8;
  localparam int WB_GW = 3;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  // LSB position of lane k in a vector that packs one w-bit field per master.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stalled-strobe counter: expire_o fires on the cycle that completes the
// (TIMEOUT-1)th consecutive stalled cycle; saturates instead of wrapping.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i & ~clr_i & (cnt_q >= CNT_LAST);

endmodule

// File: rtl/wb_master_mux.sv
// Routes the granted Wishbone master onto the shared slave bus, holding
// ownership for a whole CYC and aborting stalled strobes with ERR.
module wb_master_mux
  import wb_pkg::*;
#(
  parameter int          NM      = WB_NM,
  parameter int          GW      = WB_GW,
  parameter int          AW      = WB_AW,
  parameter int          DW      = WB_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [GW-1:0]        gnt_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [NM-1:0]        m_rty_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i
);

  localparam int SW = DW / 8;

  mmux_state_t   state_q, state_d;
  logic [GW-1:0] owner_q, owner_d;
  logic          own_cyc, own_stb, resp_any;
  logic          wd_en, wd_clr, wd_expire;

  assign own_cyc  = m_cyc_i[owner_q];
  assign own_stb  = m_stb_i[owner_q];
  assign resp_any = s_ack_i | s_err_i | s_rty_i;

  // Watchdog only sees genuinely stalled strobes; a response in the expiry cycle wins.
  assign wd_en  = (state_q == OWN) & own_cyc & own_stb & ~resp_any;
  assign wd_clr = ~wd_en;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (wd_en),
    .clr_i    (wd_clr),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    m_dat_o = rst_ni ? s_dat_i : '0;
    case (state_q)
      IDLE: begin
        if (m_cyc_i[gnt_i]) begin
          owner_d = gnt_i;
          state_d = OWN;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        s_cyc_o = own_cyc;
        s_stb_o = own_cyc & own_stb;
        s_we_o  = m_we_i[owner_q];
        s_sel_o = m_sel_i[lane_lsb(32'(owner_q), SW) +: SW];
        s_adr_o = m_adr_i[lane_lsb(32'(owner_q), AW) +: AW];
        s_dat_o = m_dat_i[lane_lsb(32'(owner_q), DW) +: DW];
        m_ack_o[owner_q] = s_ack_i & own_stb;
        m_err_o[owner_q] = s_err_i & own_stb;
        m_rty_o[owner_q] = s_rty_i & own_stb;
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (wd_expire) begin
          state_d = TOUT;
        end else begin
          state_d = OWN;
        end
      end
      TOUT: begin
        m_err_o[owner_q] = 1'b1;
        state_d = own_cyc ? OWN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_wb_master_mux.sv
// Randomized and directed checks of wb_master_mux against a transaction-level model.
module tb_wb_master_mux;

  localparam int NM = 8;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [2:0]        gnt;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [3:0]        sel_a [NM];
  logic [31:0]       adr_a [NM];
  logic [31:0]       wdat_a[NM];
  logic [NM*4-1:0]   m_sel;
  logic [NM*32-1:0]  m_adr, m_wdat;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [31:0]       s_dat;
  logic              s_ack, s_err, s_rty;

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction-level view: who holds the bus, whether a timeout is being reported, stall run length.
  bit busy;
  bit tout;
  int owner;
  int stall;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NM; k++) begin
      m_sel[k*4 +: 4]   = sel_a[k];
      m_adr[k*32 +: 32] = adr_a[k];
      m_wdat[k*32 +: 32] = wdat_a[k];
    end
  end

  wb_master_mux #(.TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .gnt_i   (gnt),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_sel_i (m_sel),
    .m_adr_i (m_adr),
    .m_dat_i (m_wdat),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_sel_o (s_sel_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .s_rty_i (s_rty)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Settle after the inputs changed, then compare every output with the model.
  task automatic eval();
    logic [6:0]  e_ctl;
    logic [31:0] e_adr, e_dat, e_mdat;
    logic [23:0] e_rsp;
    #1;
    e_ctl = '0; e_adr = '0; e_dat = '0; e_rsp = '0; e_mdat = '0;
    if (rst_ni) begin
      e_mdat = s_dat;
      if (busy) begin
        e_ctl = {m_cyc[owner], m_cyc[owner] & m_stb[owner], m_we[owner], sel_a[owner]};
        e_adr = adr_a[owner];
        e_dat = wdat_a[owner];
        if (m_stb[owner]) begin
          e_rsp[16 + owner] = s_ack;
          e_rsp[8 + owner]  = s_err;
          e_rsp[owner]      = s_rty;
        end
      end else if (tout) begin
        e_rsp[8 + owner] = 1'b1;
      end
    end
    chk_eq("s_ctrl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'(e_ctl));
    chk_eq("s_adr",  64'(s_adr_o), 64'(e_adr));
    chk_eq("s_dat",  64'(s_dat_o), 64'(e_dat));
    chk_eq("m_resp", 64'({m_ack_o, m_err_o, m_rty_o}), 64'(e_rsp));
    chk_eq("m_dat",  64'(m_dat_o), 64'(e_mdat));
  endtask

  // Clock edge: advance the model with the inputs that were held across it.
  task automatic advance();
    @(posedge clk);
    if (!rst_ni) begin
      busy = 1'b0; tout = 1'b0; owner = 0; stall = 0;
    end else if (tout) begin
      tout  = 1'b0;
      busy  = m_cyc[owner];
      stall = 0;
    end else if (busy) begin
      if (!m_cyc[owner]) begin
        busy = 1'b0; stall = 0;
      end else if (m_stb[owner] && !(s_ack || s_err || s_rty)) begin
        stall++;
        if (stall == TO - 1) begin
          busy = 1'b0; tout = 1'b1; stall = 0;
        end
      end else begin
        stall = 0;
      end
    end else if (m_cyc[gnt]) begin
      busy = 1'b1; owner = int'(gnt); stall = 0;
    end
  endtask

  task automatic clear_inputs();
    gnt = '0; m_cyc = '0; m_stb = '0; m_we = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    for (int k = 0; k < NM; k++) begin
      sel_a[k] = 4'hF; adr_a[k] = 32'(k) << 8; wdat_a[k] = 32'hA000_0000 | 32'(k);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clear_inputs(); eval(); advance();
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    busy = 1'b0; tout = 1'b0; owner = 0; stall = 0;
    @(negedge clk); eval();
    chk_eq("rst_scyc", 64'(s_cyc_o), 64'd0);
    advance();
    @(negedge clk); rst_ni = 1'b1; eval(); advance();

    // Single read from master 2.
    @(negedge clk); gnt = 3'd2; m_cyc[2] = 1'b1; m_stb[2] = 1'b1; adr_a[2] = 32'h100;
    eval(); chk_eq("rd_lat0", 64'(s_cyc_o), 64'd0); advance();
    @(negedge clk); eval();
    chk_eq("rd_cyc", 64'(s_cyc_o), 64'd1);
    chk_eq("rd_adr", 64'(s_adr_o), 64'h100);
    advance();
    @(negedge clk); s_ack = 1'b1; s_dat = 32'hDEADBEEF; eval();
    chk_eq("rd_ack", 64'(m_ack_o), 64'h04);
    chk_eq("rd_dat", 64'(m_dat_o), 64'hDEADBEEF);
    advance();
    idle_cycles(2);

    // Grant moves while master 2 holds CYC.
    @(negedge clk); gnt = 3'd2; m_cyc[2] = 1'b1; m_cyc[5] = 1'b1; adr_a[2] = 32'h200; adr_a[5] = 32'h500;
    eval(); advance();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); gnt = 3'd5; eval(); chk_eq("gnt_hold", 64'(s_adr_o), 64'h200); advance();
    end
    @(negedge clk); m_cyc[2] = 1'b0; eval(); chk_eq("drop_cyc", 64'(s_cyc_o), 64'd0); advance();
    @(negedge clk); eval(); chk_eq("idle_gap", 64'(s_cyc_o), 64'd0); advance();
    @(negedge clk); eval(); chk_eq("relock5", 64'(s_adr_o), 64'h500); advance();
    idle_cycles(2);

    // Watchdog expiry on master 1.
    @(negedge clk); gnt = 3'd1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1; eval(); advance();
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk); eval(); chk_eq("stall_noerr", 64'(m_err_o), 64'd0); advance();
    end
    @(negedge clk); eval();
    chk_eq("tout_err", 64'(m_err_o), 64'h02);
    chk_eq("tout_stb", 64'(s_stb_o), 64'd0);
    advance();
    @(negedge clk); eval(); chk_eq("tout_back", 64'(s_stb_o), 64'd1); advance();
    idle_cycles(2);

    // Response races the expiry cycle.
    @(negedge clk); gnt = 3'd1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1; eval(); advance();
    for (int i = 0; i < TO - 2; i++) begin
      @(negedge clk); eval(); advance();
    end
    @(negedge clk); s_ack = 1'b1; eval();
    chk_eq("race_ack", 64'(m_ack_o), 64'h02);
    chk_eq("race_err", 64'(m_err_o), 64'd0);
    advance();
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk); s_ack = 1'b0; eval(); chk_eq("race_clr", 64'(m_err_o), 64'd0); advance();
    end
    @(negedge clk); eval(); chk_eq("race_tout", 64'(m_err_o), 64'h02); advance();
    idle_cycles(2);

    // Isolation: response without owner strobe.
    @(negedge clk); gnt = 3'd0; m_cyc[0] = 1'b1; m_cyc[3] = 1'b1; m_stb[3] = 1'b1; eval(); advance();
    @(negedge clk); s_rty = 1'b1; s_ack = 1'b1; eval();
    chk_eq("iso_rty", 64'(m_rty_o), 64'd0);
    chk_eq("iso_ack", 64'(m_ack_o), 64'd0);
    advance();

    // Reset asserted mid-transfer with a live ACK.
    @(negedge clk); m_stb[0] = 1'b1; s_ack = 1'b1; s_dat = 32'h1234_5678; eval(); advance();
    @(negedge clk); rst_ni = 1'b0; eval();
    chk_eq("rst_out", 64'({s_cyc_o, s_stb_o, m_ack_o, m_dat_o}), 64'd0);
    advance();
    @(negedge clk); rst_ni = 1'b1; s_ack = 1'b0; m_cyc = '0; eval();
    chk_eq("rst_idle", 64'(s_cyc_o), 64'd0);
    advance();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clk);
      rst_ni = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 99) < 30) gnt = 3'($urandom_range(0, 7));
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 99) < 8) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = ($urandom_range(0, 99) < 75);
        m_we[k]  = 1'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          adr_a[k] = $urandom; wdat_a[k] = $urandom; sel_a[k] = 4'($urandom);
        end
      end
      r = $urandom_range(0, 99);
      s_ack = (r < 18) || (r >= 97);
      s_err = (r >= 18 && r < 22) || (r >= 98);
      s_rty = (r >= 22 && r < 26);
      s_dat = $urandom;
      eval();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
